// File: rtl/idp_pkg.sv
// Shared datapath constants for the operand-fetch / write-back stage and the ALU it feeds.
package idp_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam logic [3:0] ALU_PASS_S = 4'b0000;
    localparam logic [3:0] ALU_PASS_R = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0011;
    localparam logic [3:0] ALU_AND    = 4'b0100;
    localparam logic [3:0] ALU_OR     = 4'b0101;
    localparam logic [3:0] ALU_XOR    = 4'b0110;
    localparam logic [3:0] ALU_NOT    = 4'b0111;
    localparam logic [3:0] ALU_SHL    = 4'b1000;
    localparam logic [3:0] ALU_SHR    = 4'b1001;
    localparam logic [3:0] ALU_INC    = 4'b1010;
    localparam logic [3:0] ALU_DEC    = 4'b1011;
    localparam logic [3:0] ALU_NEG    = 4'b1100;

    // Bit positions inside the packed {N,Z,C} status vector.
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef logic [2:0] flags_t;

endpackage

// File: rtl/regfile_2r2w.sv
// Register array with two asynchronous read ports and two synchronous write ports.
// Port B (ALU write-back) overrides port A (external load) on an address collision.
module regfile_2r2w #(
    parameter int DATA_W = idp_pkg::DATA_W,
    parameter int ADDR_W = idp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] ra_adr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_adr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_adr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_data
);
    import idp_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wa_en) mem_d[wa_adr] = wa_data;
        if (wb_en) mem_d[wb_adr] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    assign ra_data = mem_q[ra_adr];
    assign rb_data = mem_q[rb_adr];

endmodule

// File: rtl/operand_regfile.sv
// Operand-fetch / write-back stage around the combinational ALU: register file,
// registered R/S/Alu_OP, result forwarding, status-flag latch and retired-op counter.
module operand_regfile #(
    parameter int DATA_W = idp_pkg::DATA_W,
    parameter int ADDR_W = idp_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] r_adr,
    input  logic [ADDR_W-1:0] s_adr,
    input  logic [ADDR_W-1:0] w_adr,
    input  logic              w_en,
    input  logic              f_en,
    input  logic [3:0]        op_in,
    input  logic              hold,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    output logic [3:0]        Alu_OP,
    output logic              ex_valid,
    input  logic [DATA_W-1:0] Y,
    input  logic              N,
    input  logic              Z,
    input  logic              C,
    output logic              N_q,
    output logic              Z_q,
    output logic              C_q,
    output logic [CNT_W-1:0]  retired
);
    import idp_pkg::*;

    logic [DATA_W-1:0] r_q, r_d, s_q, s_d;
    logic [DATA_W-1:0] rf_r_data, rf_s_data, r_fwd, s_fwd;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] w_adr_q, w_adr_d;
    logic              w_en_q, w_en_d, f_en_q, f_en_d;
    flags_t            flags_q, flags_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              accept, wb_fire, wb_wr;

    assign op_ready = ~hold;
    assign accept   = op_valid & ~hold;
    assign wb_fire  = ex_valid_q & ~hold;
    assign wb_wr    = wb_fire & w_en_q;

    regfile_2r2w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clk     (clk),
        .clr_n   (reset_n),
        .ra_adr  (r_adr),
        .ra_data (rf_r_data),
        .rb_adr  (s_adr),
        .rb_data (rf_s_data),
        .wa_en   (ld_en),
        .wa_adr  (ld_adr),
        .wa_data (ld_data),
        .wb_en   (wb_wr),
        .wb_adr  (w_adr_q),
        .wb_data (Y)
    );

    // The result being written this edge beats a same-edge load, which beats the array.
    always_comb begin
        r_fwd = rf_r_data;
        s_fwd = rf_s_data;
        if (ld_en && ld_adr == r_adr) r_fwd = ld_data;
        if (ld_en && ld_adr == s_adr) s_fwd = ld_data;
        if (wb_wr && w_adr_q == r_adr) r_fwd = Y;
        if (wb_wr && w_adr_q == s_adr) s_fwd = Y;
    end

    always_comb begin
        r_d        = r_q;
        s_d        = s_q;
        alu_op_d   = alu_op_q;
        w_adr_d    = w_adr_q;
        w_en_d     = w_en_q;
        f_en_d     = f_en_q;
        ex_valid_d = hold ? ex_valid_q : op_valid;
        flags_d    = flags_q;
        retired_d  = retired_q;
        if (accept) begin
            r_d      = r_fwd;
            s_d      = s_fwd;
            alu_op_d = op_in;
            w_adr_d  = w_adr;
            w_en_d   = w_en;
            f_en_d   = f_en;
        end
        if (wb_fire) begin
            retired_d = retired_q + CNT_W'(1);
            if (f_en_q) begin
                flags_d[FLAG_N] = N;
                flags_d[FLAG_Z] = Z;
                flags_d[FLAG_C] = C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q        <= '0;
            s_q        <= '0;
            alu_op_q   <= '0;
            w_adr_q    <= '0;
            w_en_q     <= 1'b0;
            f_en_q     <= 1'b0;
            ex_valid_q <= 1'b0;
            flags_q    <= '0;
            retired_q  <= '0;
        end else begin
            r_q        <= r_d;
            s_q        <= s_d;
            alu_op_q   <= alu_op_d;
            w_adr_q    <= w_adr_d;
            w_en_q     <= w_en_d;
            f_en_q     <= f_en_d;
            ex_valid_q <= ex_valid_d;
            flags_q    <= flags_d;
            retired_q  <= retired_d;
        end
    end

    assign R        = r_q;
    assign S        = s_q;
    assign Alu_OP   = alu_op_q;
    assign ex_valid = ex_valid_q;
    assign N_q      = flags_q[FLAG_N];
    assign Z_q      = flags_q[FLAG_Z];
    assign C_q      = flags_q[FLAG_C];
    assign retired  = retired_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile with a behavioural 16-bit ALU closing the Y/N/Z/C loop;
// a second instance with a 4-bit counter exercises the retired-count wrap cheaply.
module tb_operand_regfile;
    import idp_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        op_valid, op_ready, sm_op_ready;
    logic [2:0]  r_adr, s_adr, w_adr, ld_adr;
    logic        w_en, f_en, hold, ld_en;
    logic [3:0]  op_in;
    logic [15:0] ld_data;
    logic [15:0] R, S, Y, sm_R, sm_S;
    logic [3:0]  Alu_OP, sm_Alu_OP;
    logic        ex_valid, sm_ex_valid;
    logic        N, Z, C, N_q, Z_q, C_q, sm_N_q, sm_Z_q, sm_C_q;
    logic [15:0] retired;
    logic [3:0]  sm_retired;
    logic [15:0] alu_y;
    logic        alu_c;

    int n_assert = 0;
    int n_fail   = 0;

    operand_regfile dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .r_adr(r_adr), .s_adr(s_adr), .w_adr(w_adr), .w_en(w_en), .f_en(f_en),
        .op_in(op_in), .hold(hold), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
        .R(R), .S(S), .Alu_OP(Alu_OP), .ex_valid(ex_valid),
        .Y(Y), .N(N), .Z(Z), .C(C), .N_q(N_q), .Z_q(Z_q), .C_q(C_q), .retired(retired)
    );

    operand_regfile #(.CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(sm_op_ready),
        .r_adr(r_adr), .s_adr(s_adr), .w_adr(w_adr), .w_en(w_en), .f_en(f_en),
        .op_in(op_in), .hold(hold), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
        .R(sm_R), .S(sm_S), .Alu_OP(sm_Alu_OP), .ex_valid(sm_ex_valid),
        .Y(Y), .N(N), .Z(Z), .C(C), .N_q(sm_N_q), .Z_q(sm_Z_q), .C_q(sm_C_q),
        .retired(sm_retired)
    );

    // Behavioural ALU; SUB reports borrow in C.
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        case (Alu_OP)
            ALU_PASS_S: alu_y = S;
            ALU_PASS_R: alu_y = R;
            ALU_ADD:    {alu_c, alu_y} = {1'b0, R} + {1'b0, S};
            ALU_SUB:    {alu_c, alu_y} = {1'b0, R} - {1'b0, S};
            ALU_AND:    alu_y = R & S;
            ALU_OR:     alu_y = R | S;
            ALU_XOR:    alu_y = R ^ S;
            ALU_NOT:    alu_y = ~R;
            ALU_SHL:    {alu_c, alu_y} = {R, 1'b0};
            ALU_SHR:    {alu_y, alu_c} = {1'b0, R};
            ALU_INC:    {alu_c, alu_y} = {1'b0, R} + 17'd1;
            ALU_DEC:    {alu_c, alu_y} = {1'b0, R} - 17'd1;
            ALU_NEG:    {alu_c, alu_y} = 17'd0 - {1'b0, R};
            default:    alu_y = '0;
        endcase
    end

    assign Y = alu_y;
    assign N = alu_y[15];
    assign Z = (alu_y == 16'h0000);
    assign C = alu_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [2:0] ra, input logic [2:0] sa,
                          input logic [2:0] wa, input logic we, input logic fe,
                          input logic [3:0] op);
        op_valid = v; r_adr = ra; s_adr = sa; w_adr = wa; w_en = we; f_en = fe; op_in = op;
    endtask

    task automatic set_ld(input logic en, input logic [2:0] a, input logic [15:0] d);
        ld_en = en; ld_adr = a; ld_data = d;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        hold    = 1'b0;
        set_op(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, ALU_ADD);
        set_ld(1'b1, 3'd1, 16'h5555);
        tick();
        tick();
        n_assert++; if (R !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_R: got %h want %h", R, 16'h0000); end
        n_assert++; if (S !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_S: got %h want %h", S, 16'h0000); end
        n_assert++; if (Alu_OP !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_op: got %h want %h", Alu_OP, 4'h0); end
        n_assert++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_exv: got %b want 0", ex_valid); end
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {N_q, Z_q, C_q}); end
        n_assert++; if (retired !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_retired: got %h want 0000", retired); end
        n_assert++; if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", op_ready); end
        reset_n = 1'b1;
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S);
        set_ld(1'b0, 3'd0, 16'h0000);
    endtask

    task automatic test_add;
        set_ld(1'b1, 3'd1, 16'h0005); tick();
        set_ld(1'b1, 3'd2, 16'h0003); tick();
        set_ld(1'b0, 3'd0, 16'h0000);
        set_op(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, ALU_ADD); tick();
        n_assert++; if (R !== 16'h0005) begin n_fail++; $display("[TB] FAIL add_R: got %h want %h", R, 16'h0005); end
        n_assert++; if (S !== 16'h0003) begin n_fail++; $display("[TB] FAIL add_S: got %h want %h", S, 16'h0003); end
        n_assert++; if (Alu_OP !== ALU_ADD) begin n_fail++; $display("[TB] FAIL add_op: got %h want %h", Alu_OP, ALU_ADD); end
        n_assert++; if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_exv: got %b want 1", ex_valid); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL add_idle_exv: got %b want 0", ex_valid); end
        n_assert++; if (retired !== 16'd1) begin n_fail++; $display("[TB] FAIL add_retired: got %0d want 1", retired); end
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b000) begin n_fail++; $display("[TB] FAIL add_flags: got %b want 000", {N_q, Z_q, C_q}); end
        set_op(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'h0008) begin n_fail++; $display("[TB] FAIL add_r3: got %h want %h", R, 16'h0008); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
    endtask

    task automatic test_back_to_back;
        set_ld(1'b1, 3'd3, 16'h0000); tick();
        set_ld(1'b0, 3'd0, 16'h0000);
        set_op(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, ALU_ADD); tick();
        set_op(1'b1, 3'd3, 3'd1, 3'd4, 1'b1, 1'b0, ALU_SUB);
        n_assert++; if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready: got %b want 1", op_ready); end
        tick();
        n_assert++; if (R !== 16'h0008) begin n_fail++; $display("[TB] FAIL b2b_fwd_R: got %h want %h", R, 16'h0008); end
        n_assert++; if (S !== 16'h0005) begin n_fail++; $display("[TB] FAIL b2b_S: got %h want %h", S, 16'h0005); end
        n_assert++; if (Alu_OP !== ALU_SUB) begin n_fail++; $display("[TB] FAIL b2b_op: got %h want %h", Alu_OP, ALU_SUB); end
        n_assert++; if (retired !== 16'd3) begin n_fail++; $display("[TB] FAIL b2b_retired1: got %0d want 3", retired); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if (retired !== 16'd4) begin n_fail++; $display("[TB] FAIL b2b_retired2: got %0d want 4", retired); end
        set_op(1'b1, 3'd4, 3'd3, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'h0003) begin n_fail++; $display("[TB] FAIL b2b_r4: got %h want %h", R, 16'h0003); end
        n_assert++; if (S !== 16'h0008) begin n_fail++; $display("[TB] FAIL b2b_r3: got %h want %h", S, 16'h0008); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
    endtask

    task automatic test_flags;
        set_op(1'b1, 3'd2, 3'd1, 3'd7, 1'b1, 1'b1, ALU_SUB); tick();
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b101) begin n_fail++; $display("[TB] FAIL flags_sub: got %b want 101", {N_q, Z_q, C_q}); end
        n_assert++; if (retired !== 16'd6) begin n_fail++; $display("[TB] FAIL flags_retired: got %0d want 6", retired); end
        set_op(1'b1, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL flags_r7: got %h want %h", R, 16'hFFFE); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b101) begin n_fail++; $display("[TB] FAIL flags_kept: got %b want 101", {N_q, Z_q, C_q}); end
        set_op(1'b1, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1, ALU_SUB); tick();
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b010) begin n_fail++; $display("[TB] FAIL flags_zero: got %b want 010", {N_q, Z_q, C_q}); end
        n_assert++; if (retired !== 16'd8) begin n_fail++; $display("[TB] FAIL flags_retired2: got %0d want 8", retired); end
    endtask

    task automatic test_hold;
        set_op(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1, ALU_ADD); tick();
        hold = 1'b1;
        set_op(1'b1, 3'd2, 3'd1, 3'd6, 1'b1, 1'b1, ALU_SUB);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_ld(1'b1, 3'd0, 16'h0077);
            else        set_ld(1'b0, 3'd0, 16'h0000);
            tick();
            n_assert++; if (R !== 16'h0005) begin n_fail++; $display("[TB] FAIL hold_R[%0d]: got %h want %h", i, R, 16'h0005); end
            n_assert++; if (S !== 16'h0003) begin n_fail++; $display("[TB] FAIL hold_S[%0d]: got %h want %h", i, S, 16'h0003); end
            n_assert++; if (Alu_OP !== ALU_ADD) begin n_fail++; $display("[TB] FAIL hold_op[%0d]: got %h want %h", i, Alu_OP, ALU_ADD); end
            n_assert++; if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_exv[%0d]: got %b want 1", i, ex_valid); end
            n_assert++; if (op_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_ready[%0d]: got %b want 0", i, op_ready); end
            n_assert++; if ({N_q, Z_q, C_q} !== 3'b010) begin n_fail++; $display("[TB] FAIL hold_flags[%0d]: got %b want 010", i, {N_q, Z_q, C_q}); end
            n_assert++; if (retired !== 16'd8) begin n_fail++; $display("[TB] FAIL hold_retired[%0d]: got %0d want 8", i, retired); end
        end
        hold = 1'b0;
        set_ld(1'b0, 3'd0, 16'h0000);
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_exv: got %b want 0", ex_valid); end
        n_assert++; if (retired !== 16'd9) begin n_fail++; $display("[TB] FAIL release_retired: got %0d want 9", retired); end
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b000) begin n_fail++; $display("[TB] FAIL release_flags: got %b want 000", {N_q, Z_q, C_q}); end
        set_op(1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'h0008) begin n_fail++; $display("[TB] FAIL release_r6: got %h want %h", R, 16'h0008); end
        n_assert++; if (S !== 16'h0077) begin n_fail++; $display("[TB] FAIL hold_ld_r0: got %h want %h", S, 16'h0077); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if (retired !== 16'd10) begin n_fail++; $display("[TB] FAIL release_retired2: got %0d want 10", retired); end
    endtask

    task automatic test_ld_collision;
        set_op(1'b1, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, ALU_ADD); tick();
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S);
        set_ld(1'b1, 3'd5, 16'h1234); tick();
        set_ld(1'b0, 3'd0, 16'h0000);
        set_op(1'b1, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'h0008) begin n_fail++; $display("[TB] FAIL coll_r5: got %h want %h", R, 16'h0008); end
        set_ld(1'b1, 3'd6, 16'h00AA);
        set_op(1'b1, 3'd6, 3'd5, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'h00AA) begin n_fail++; $display("[TB] FAIL ldfwd_R: got %h want %h", R, 16'h00AA); end
        n_assert++; if (S !== 16'h0008) begin n_fail++; $display("[TB] FAIL ldfwd_S: got %h want %h", S, 16'h0008); end
        set_ld(1'b0, 3'd0, 16'h0000);
        set_op(1'b1, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (S !== 16'h00AA) begin n_fail++; $display("[TB] FAIL ld_r6: got %h want %h", S, 16'h00AA); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if (retired !== 16'd14) begin n_fail++; $display("[TB] FAIL coll_retired: got %0d want 14", retired); end
    endtask

    task automatic test_reset_inflight;
        set_op(1'b1, 3'd1, 3'd2, 3'd2, 1'b1, 1'b1, ALU_ADD); tick();
        reset_n = 1'b0;
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if ({R, S} !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_RS: got %h want 0", {R, S}); end
        n_assert++; if ({Alu_OP, ex_valid} !== 5'h0) begin n_fail++; $display("[TB] FAIL rst_op_exv: got %h want 0", {Alu_OP, ex_valid}); end
        n_assert++; if ({N_q, Z_q, C_q} !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_flags: got %b want 000", {N_q, Z_q, C_q}); end
        n_assert++; if (retired !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_retired: got %h want 0000", retired); end
        n_assert++; if ({sm_R, sm_S, sm_Alu_OP, sm_ex_valid, sm_N_q, sm_Z_q, sm_C_q, sm_retired} !== 44'h0)
            begin n_fail++; $display("[TB] FAIL rst_small: got %h want 0", {sm_R, sm_S, sm_Alu_OP, sm_ex_valid, sm_N_q, sm_Z_q, sm_C_q, sm_retired}); end
        n_assert++; if (sm_op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_small_ready: got %b want 1", sm_op_ready); end
        reset_n = 1'b1;
        set_op(1'b1, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, ALU_PASS_R); tick();
        n_assert++; if (R !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_r2: got %h want 0000", R); end
        n_assert++; if (S !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_r1: got %h want 0000", S); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        set_op(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S);
        for (int i = 0; i < 15; i++) tick();
        n_assert++; if (retired !== 16'd15) begin n_fail++; $display("[TB] FAIL wrap_pre: got %0d want 15", retired); end
        n_assert++; if (sm_retired !== 4'hF) begin n_fail++; $display("[TB] FAIL wrap_pre_small: got %h want F", sm_retired); end
        set_op(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS_S); tick();
        n_assert++; if (retired !== 16'd16) begin n_fail++; $display("[TB] FAIL wrap_main: got %0d want 16", retired); end
        n_assert++; if (sm_retired !== 4'h0) begin n_fail++; $display("[TB] FAIL wrap_small: got %h want 0", sm_retired); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_flags();
        test_hold();
        test_ld_collision();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
